// File: rtl/conv_sequencer_pkg.sv
// Shared types and constants for the convolution sequencer.
// Holds the FSM state encoding, the pixel/weight data width and the
// width of the kernel weight index bus.
package conv_sequencer_pkg;

    localparam int DATA_W = 8;
    localparam int WIDX_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        LOAD_W = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/conv_sequencer_out_fifo.sv
// seq_out_fifo: synchronous result buffer, DEPTH entries of WIDTH bits.
// Ports: push/push_data write, pop reads head; head is zero while empty;
// count is the current occupancy. Push is refused only when full with no pop.
module seq_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO may still accept a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: stale entries are never visible while count is zero.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences one frame through an external KxK convolution kernel.
// Ports: start/busy/done frame control; w_* weight stream; pix_* pixel stream;
// k_* kernel control (clear, weight load, pixel strobe, result in); out_* result stream.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int KLAT   = 2,
    parameter int FIFO_D = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DATA_W-1:0] w_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              k_clear,
    output logic              k_weight_we,
    output logic [WIDX_W-1:0] k_weight_idx,
    output logic [DATA_W-1:0] k_weight,
    output logic              k_pixel_en,
    output logic [DATA_W-1:0] k_pixel,
    input  logic [DATA_W-1:0] k_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FCNT_W = $clog2(FIFO_D + 1);
    localparam int OCC_W  = $clog2(FIFO_D + KLAT + 1);
    localparam int NW     = K * K;

    state_t              state;
    state_t              state_nxt;
    logic [WIDX_W-1:0]   w_idx;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [KLAT-1:0]     tag_sr;
    logic [FCNT_W-1:0]   fifo_count;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_head;
    logic [OCC_W-1:0]    occupancy;
    logic                w_hs;
    logic                pix_hs;
    logic                last_w;
    logic                last_col;
    logic                last_row;
    logic                last_pix;
    logic                window;
    logic                out_pop;

    assign last_w   = (w_idx == WIDX_W'(NW - 1));
    assign last_col = (col == COL_W'(IMG_W - 1));
    assign last_row = (row == ROW_W'(IMG_H - 1));
    assign last_pix = last_col && last_row;
    assign window   = (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));

    // Buffer slots already promised: stored results plus results still
    // travelling through the kernel. Admitting a pixel only while this is
    // below the depth guarantees every tag finds a free slot on exit.
    always_comb begin
        occupancy = OCC_W'(fifo_count);
        for (int i = 0; i < KLAT; i++) begin
            occupancy = occupancy + OCC_W'(tag_sr[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        k_clear   = 1'b0;
        w_ready   = 1'b0;
        pix_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                k_clear   = 1'b1;
                state_nxt = LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && last_w) state_nxt = STREAM;
            end
            STREAM: begin
                pix_ready = (occupancy < OCC_W'(FIFO_D));
                if (pix_valid && pix_ready && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                if ((tag_sr == '0) && fifo_empty) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign w_hs   = w_valid && w_ready;
    assign pix_hs = pix_valid && pix_ready;

    // Data outputs are gated by their strobes so nothing toggles while idle
    // or held in reset.
    assign k_weight_we  = w_hs;
    assign k_weight_idx = w_hs ? w_idx : '0;
    assign k_weight     = w_hs ? w_data : '0;
    assign k_pixel_en   = pix_hs;
    assign k_pixel      = pix_hs ? pix_data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_idx <= '0;
            col   <= '0;
            row   <= '0;
        end else if (state == CLEAR) begin
            w_idx <= '0;
            col   <= '0;
            row   <= '0;
        end else begin
            if (w_hs) w_idx <= w_idx + WIDX_W'(1);
            if (pix_hs) begin
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
        end
    end

    // Tag pipeline mirrors the kernel latency: a set bit at the last stage
    // means k_dout holds the result of a window pixel this cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_sr <= '0;
        end else begin
            tag_sr[0] <= pix_hs && window;
            for (int i = 1; i < KLAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_head;
    assign out_pop   = out_valid && out_ready;

    seq_out_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (DATA_W)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (tag_sr[KLAT-1]),
        .push_data (k_dout),
        .pop       (out_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with a stand-in kernel whose result is
// a fixed map of the pixel delayed KLAT cycles.
module tb_conv_sequencer;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int K      = 3;
    localparam int KLAT   = 2;
    localparam int FIFO_D = 4;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NOUT   = (IMG_W - K + 1) * (IMG_H - K + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done;
    logic       w_valid = 1'b0, w_ready;
    logic [7:0] w_data = '0;
    logic       pix_valid = 1'b0, pix_ready;
    logic [7:0] pix_data = '0;
    logic       k_clear, k_weight_we;
    logic [3:0] k_weight_idx;
    logic [7:0] k_weight;
    logic       k_pixel_en;
    logic [7:0] k_pixel;
    logic [7:0] k_dout;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    conv_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .KLAT(KLAT), .FIFO_D(FIFO_D)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .k_clear(k_clear), .k_weight_we(k_weight_we), .k_weight_idx(k_weight_idx),
        .k_weight(k_weight), .k_pixel_en(k_pixel_en), .k_pixel(k_pixel),
        .k_dout(k_dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    // Stand-in kernel: KLAT register stages, then result = pixel*3+1.
    logic [7:0] kp [KLAT];
    always @(posedge clock) begin
        kp[0] <= k_pixel;
        for (int i = 1; i < KLAT; i++) kp[i] <= kp[i-1];
    end
    assign k_dout = kp[KLAT-1] * 8'd3 + 8'd1;

    function automatic bit is_win(input int n);
        return ((n / IMG_W) >= K - 1) && ((n % IMG_W) >= K - 1);
    endfunction

    function automatic int win_upto(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (is_win(i)) c++;
        return c;
    endfunction

    function automatic int exp_of(input int base, input int i);
        logic [7:0] p;
        logic [7:0] r;
        p = 8'(base + i);
        r = p * 8'd3 + 8'd1;
        return int'(r);
    endfunction

    // Monitor: per-frame records, restarted on each kernel clear.
    int         cyc = 0, clear_total = 0, done_cnt = 0, hs_cnt = 0;
    int         first_win = -1, first_out = -1, first_hs = -1, last_hs = -1;
    logic [7:0] got[$];
    int         widx_q[$];
    int         wval_q[$];

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (k_clear) begin
                clear_total++;
                hs_cnt = 0; done_cnt = 0;
                first_win = -1; first_out = -1; first_hs = -1; last_hs = -1;
                got.delete(); widx_q.delete(); wval_q.delete();
            end
            if (k_weight_we) begin
                widx_q.push_back(int'(k_weight_idx));
                wval_q.push_back(int'(k_weight));
            end
            if (k_pixel_en) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                if (first_win < 0 && is_win(hs_cnt)) first_win = cyc;
                hs_cnt++;
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input int got_v, input int exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_weights();
        int t;
        for (int j = 0; j < K * K; j++) begin
            w_valid = 1'b1;
            w_data  = 8'(j + 1);
            t = 0;
            @(negedge clock);
            while (!w_ready && t < 100) begin @(negedge clock); t++; end
            if (!w_ready) begin
                check("w_ready_timeout", 0, 1);
                w_valid = 1'b0;
                return;
            end
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic drive_pixels(input int base, input bit gapped, input int start_at, input int reset_at);
        int t;
        for (int i = 0; i < NPIX; i++) begin
            if (i == reset_at) begin
                pix_valid = 1'b0;
                reset = 1'b0;
                #1;
                check("rst_mid_busy", busy, 0);
                check("rst_mid_out_valid", out_valid, 0);
                check("rst_mid_pix_ready", pix_ready, 0);
                check("rst_mid_w_ready", w_ready, 0);
                check("rst_mid_done", done, 0);
                check("rst_mid_out_data", out_data, 0);
                tick(); tick();
                reset = 1'b1;
                tick();
                return;
            end
            pix_valid = 1'b1;
            pix_data  = 8'(base + i);
            start     = (i == start_at);
            t = 0;
            @(negedge clock);
            while (!pix_ready && t < 200) begin @(negedge clock); t++; end
            if (!pix_ready) begin
                check("pix_ready_timeout", 0, 1);
                pix_valid = 1'b0;
                start = 1'b0;
                return;
            end
            tick();
            start = 1'b0;
            if (gapped) begin
                pix_valid = 1'b0;
                tick();
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic stall_outputs(input int at);
        int t = 0;
        while (hs_cnt < at && t < 2000) begin @(negedge clock); #1; t++; end
        check("bp_reached", int'(hs_cnt >= at), 1);
        @(posedge clock); #1;
        out_ready = 1'b0;
        repeat (20) @(posedge clock);
        @(negedge clock); #1;
        check("bp_pix_ready", pix_ready, 0);
        check("bp_held", win_upto(hs_cnt) - got.size(), FIFO_D);
        check("bp_out_valid", out_valid, 1);
        @(posedge clock); #1;
        out_ready = 1'b1;
    endtask

    task automatic verify_frame(input int base);
        int t = 0;
        int exp_q[$];
        while (done_cnt == 0 && t < 500) begin @(negedge clock); #1; t++; end
        repeat (3) @(negedge clock);
        #1;
        check("done_pulses", done_cnt, 1);
        check("busy_after_done", busy, 0);
        check("handshakes", hs_cnt, NPIX);
        check("out_count", got.size(), NOUT);
        for (int i = 0; i < NPIX; i++) if (is_win(i)) exp_q.push_back(exp_of(base, i));
        for (int j = 0; j < NOUT; j++) begin
            check("out_data", (j < got.size()) ? int'(got[j]) : -1, exp_q[j]);
        end
    endtask

    initial begin
        int c0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_k_clear", k_clear, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        tick();

        // Frame 1: back-to-back pixels, free-flowing output.
        c0 = clear_total;
        start_frame();
        load_weights();
        drive_pixels(0, 1'b0, -1, -1);
        verify_frame(0);
        check("f1_clear_cycles", clear_total - c0, 1);
        check("f1_weight_count", widx_q.size(), K * K);
        for (int j = 0; j < K * K && j < widx_q.size(); j++) begin
            check("f1_weight_idx", widx_q[j], j);
            check("f1_weight_val", wval_q[j], j + 1);
        end
        check("f1_first_out_latency", first_out - first_win, KLAT + 1);
        check("f1_no_stall_span", last_hs - first_hs, NPIX - 1);

        // Frame 2: output backpressure plus a start pulse mid-stream.
        c0 = clear_total;
        start_frame();
        load_weights();
        fork
            drive_pixels(100, 1'b0, 40, -1);
            stall_outputs(30);
        join
        verify_frame(100);
        check("f2_clear_cycles", clear_total - c0, 1);

        // Frame 3: reset after 30 pixels, then a clean frame.
        start_frame();
        load_weights();
        drive_pixels(50, 1'b0, -1, 30);
        start_frame();
        load_weights();
        drive_pixels(7, 1'b0, -1, -1);
        verify_frame(7);

        // Frame 4: pixel stream with an idle cycle after every pixel.
        start_frame();
        load_weights();
        drive_pixels(200, 1'b1, -1, -1);
        verify_frame(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
